// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// Shares one Avalon-style memory bus between the instruction-fetch port and
// the data port of a Harvard MIPS core. One transaction at a time: arbitrate
// in IDLE, drive the bus from registers in I_BUS/D_BUS, then pulse the
// completion strobe of the served port for one cycle in RESP. A saturating
// watchdog ends transactions whose waitrequest never drops and raises a
// sticky bus error so the core cannot deadlock.

module mips_mem_arbiter #(
  parameter int DATA_FIRST = 1,
  parameter int TIMEOUT    = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_instr_req,
  input  logic [31:0] i_instr_addr,
  output logic [31:0] o_instr_readdata,
  output logic        o_instr_valid,
  input  logic        i_data_req,
  input  logic        i_data_we,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  input  logic [3:0]  i_data_be,
  output logic [31:0] o_data_readdata,
  output logic        o_data_done,
  output logic [31:0] o_mem_address,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_mem_writedata,
  output logic [3:0]  o_mem_byteenable,
  input  logic [31:0] i_mem_readdata,
  input  logic        i_mem_waitrequest,
  output logic        o_bus_error
);

  localparam int               CNT_W        = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [31:0]      TIMEOUT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_I_BUS = 2'd1,
    S_D_BUS = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_last_data;   // 1: data port was served last, 0: instruction port
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_read;
  logic             r_mem_write;
  logic [31:0]      r_mem_address;
  logic [31:0]      r_mem_writedata;
  logic [3:0]       r_mem_byteenable;
  logic [31:0]      r_instr_readdata;
  logic [31:0]      r_data_readdata;
  logic             r_instr_valid;
  logic             r_data_done;
  logic             r_bus_error;

  logic             w_pick_data;
  logic             w_any_req;
  logic             w_strobe;
  logic             w_done;
  logic             w_expire;
  logic [CNT_W-1:0] w_cnt_next;

  // Arbitration: pick the data port when it is alone, or when both request and
  // either data has fixed priority or the instruction port was served last.
  always_comb begin
    w_any_req   = i_instr_req | i_data_req;
    w_pick_data = 1'b0;
    if (i_data_req && !i_instr_req) begin
      w_pick_data = 1'b1;
    end else if (i_data_req && i_instr_req) begin
      w_pick_data = (DATA_FIRST != 0) ? 1'b1 : r_last_data == 1'b0;
    end else begin
      w_pick_data = 1'b0;
    end
  end

  // Bus completion / watchdog expiry detection and saturating counter increment.
  always_comb begin
    w_strobe   = r_mem_read | r_mem_write;
    w_done     = w_strobe & ~i_mem_waitrequest;
    w_expire   = w_strobe & i_mem_waitrequest & (r_cnt == CNT_LIMIT);
    w_cnt_next = r_cnt;
    if (r_cnt != CNT_MAX) begin
      w_cnt_next = r_cnt + CNT_ONE;
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  // Transaction FSM; every output is a register updated here. The bus address
  // is left at its last value after completion since the strobes qualify it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_last_data      <= 1'b0;
      r_cnt            <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_address    <= 32'h0000_0000;
      r_mem_writedata  <= 32'h0000_0000;
      r_mem_byteenable <= 4'h0;
      r_instr_readdata <= 32'h0000_0000;
      r_data_readdata  <= 32'h0000_0000;
      r_instr_valid    <= 1'b0;
      r_data_done      <= 1'b0;
      r_bus_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_instr_valid <= 1'b0;
          r_data_done   <= 1'b0;
          r_cnt         <= '0;
          if (w_any_req) begin
            if (w_pick_data) begin
              r_state          <= S_D_BUS;
              r_mem_read       <= ~i_data_we;
              r_mem_write      <= i_data_we;
              r_mem_address    <= i_data_addr;
              r_mem_writedata  <= i_data_wdata;
              r_mem_byteenable <= i_data_be;
            end else begin
              r_state          <= S_I_BUS;
              r_mem_read       <= 1'b1;
              r_mem_write      <= 1'b0;
              r_mem_address    <= i_instr_addr;
              r_mem_byteenable <= 4'hF;
            end
          end
        end

        S_I_BUS: begin
          if (w_done) begin
            r_state          <= S_RESP;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_instr_readdata <= i_mem_readdata;
            r_instr_valid    <= 1'b1;
            r_last_data      <= 1'b0;
            r_cnt            <= '0;
          end else if (w_expire) begin
            r_state          <= S_RESP;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_instr_readdata <= TIMEOUT_WORD;
            r_instr_valid    <= 1'b1;
            r_last_data      <= 1'b0;
            r_bus_error      <= 1'b1;
            r_cnt            <= '0;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        S_D_BUS: begin
          if (w_done) begin
            r_state     <= S_RESP;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_data_done <= 1'b1;
            r_last_data <= 1'b1;
            r_cnt       <= '0;
            if (r_mem_read) begin
              r_data_readdata <= i_mem_readdata;
            end
          end else if (w_expire) begin
            r_state     <= S_RESP;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_data_done <= 1'b1;
            r_last_data <= 1'b1;
            r_bus_error <= 1'b1;
            r_cnt       <= '0;
            if (r_mem_read) begin
              r_data_readdata <= TIMEOUT_WORD;
            end
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        S_RESP: begin
          // Requests present during the response cycle are only seen in IDLE.
          r_state       <= S_IDLE;
          r_instr_valid <= 1'b0;
          r_data_done   <= 1'b0;
        end

        default: begin
          r_state       <= S_IDLE;
          r_mem_read    <= 1'b0;
          r_mem_write   <= 1'b0;
          r_instr_valid <= 1'b0;
          r_data_done   <= 1'b0;
          r_cnt         <= '0;
        end
      endcase
    end
  end

  assign o_instr_readdata = r_instr_readdata;
  assign o_instr_valid    = r_instr_valid;
  assign o_data_readdata  = r_data_readdata;
  assign o_data_done      = r_data_done;
  assign o_mem_address    = r_mem_address;
  assign o_mem_read       = r_mem_read;
  assign o_mem_write      = r_mem_write;
  assign o_mem_writedata  = r_mem_writedata;
  assign o_mem_byteenable = r_mem_byteenable;
  assign o_bus_error      = r_bus_error;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Testbench for mips_mem_arbiter. Instance A: DATA_FIRST=1, TIMEOUT=8.
// Instance B: DATA_FIRST=0, TIMEOUT=256. Both share the same stimulus; each
// scenario only checks the instance whose configuration it exercises.

module tb_mips_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ireq;
  logic [31:0] iaddr;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dbe;
  logic [31:0] mrdata;
  logic        mwait;

  logic [31:0] a_ird, a_drd, a_addr, a_wd;
  logic        a_iv, a_dd, a_rd, a_wr, a_berr;
  logic [3:0]  a_be;
  logic [31:0] b_ird, b_drd, b_addr, b_wd;
  logic        b_iv, b_dd, b_rd, b_wr, b_berr;
  logic [3:0]  b_be;

  int checks;
  int errors;

  mips_mem_arbiter #(.DATA_FIRST(1), .TIMEOUT(8)) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_instr_req(ireq), .i_instr_addr(iaddr),
    .o_instr_readdata(a_ird), .o_instr_valid(a_iv),
    .i_data_req(dreq), .i_data_we(dwe), .i_data_addr(daddr),
    .i_data_wdata(dwdata), .i_data_be(dbe),
    .o_data_readdata(a_drd), .o_data_done(a_dd),
    .o_mem_address(a_addr), .o_mem_read(a_rd), .o_mem_write(a_wr),
    .o_mem_writedata(a_wd), .o_mem_byteenable(a_be),
    .i_mem_readdata(mrdata), .i_mem_waitrequest(mwait),
    .o_bus_error(a_berr)
  );

  mips_mem_arbiter #(.DATA_FIRST(0), .TIMEOUT(256)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_instr_req(ireq), .i_instr_addr(iaddr),
    .o_instr_readdata(b_ird), .o_instr_valid(b_iv),
    .i_data_req(dreq), .i_data_we(dwe), .i_data_addr(daddr),
    .i_data_wdata(dwdata), .i_data_be(dbe),
    .o_data_readdata(b_drd), .o_data_done(b_dd),
    .o_mem_address(b_addr), .o_mem_read(b_rd), .o_mem_write(b_wr),
    .o_mem_writedata(b_wd), .o_mem_byteenable(b_be),
    .i_mem_readdata(mrdata), .i_mem_waitrequest(mwait),
    .o_bus_error(b_berr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic        wt;
    logic [31:0] rdata;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        e_dd;
    logic [31:0] e_ird;
    logic [31:0] e_drd;
  } vec_t;

  localparam int NV = 17;
  localparam logic [31:0] IA  = 32'hBFC0_0000;
  localparam logic [31:0] DA  = 32'h0000_1000;
  localparam logic [31:0] R0  = 32'h2402_0005;
  localparam logic [31:0] R1  = 32'hCAFE_F00D;
  localparam logic [31:0] R2  = 32'h1111_2222;
  localparam logic [31:0] R3  = 32'h7777_8888;
  localparam logic [31:0] Z   = 32'h0000_0000;

  vec_t tbl [NV];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Safety net: the run is bounded by the scenario loops, this only catches a hang.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  int  wcnt, rcnt, done_c, last_wr_c, npulse;
  bit  stable, got, early_err, spurious, rd_seen_wr;
  logic [31:0] seen_ird;
  logic        seen_berr;
  logic [7:0]  order [5];
  logic [7:0]  exp_order [5];

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; ireq = 1'b0; iaddr = IA; dreq = 1'b0; dwe = 1'b0;
    daddr = DA; dwdata = Z; dbe = 4'hF; mrdata = Z; mwait = 1'b0;

    //           ireq  dreq  dwe   wt    rdata  rd    wr    addr iv    dd    ird drd
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, R0, 1'b1, 1'b0, IA, 1'b0, 1'b0, Z,  Z };
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, R0, 1'b0, 1'b0, IA, 1'b1, 1'b0, R0, Z };
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b0, IA, 1'b0, 1'b0, R0, Z };
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b0, IA, 1'b0, 1'b0, R0, Z };
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, R1, 1'b1, 1'b0, DA, 1'b0, 1'b0, R0, Z };
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, R1, 1'b0, 1'b0, DA, 1'b0, 1'b1, R0, R1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b0, DA, 1'b0, 1'b0, R0, R1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, Z,  1'b1, 1'b0, IA, 1'b0, 1'b0, R0, R1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, R2, 1'b0, 1'b0, IA, 1'b1, 1'b0, R2, R1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b0, IA, 1'b0, 1'b0, R2, R1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, Z,  1'b0, 1'b1, DA, 1'b0, 1'b0, R2, R1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, R3, 1'b0, 1'b0, DA, 1'b0, 1'b1, R2, R1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b0, DA, 1'b0, 1'b0, R2, R1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, Z,  1'b1, 1'b0, IA, 1'b0, 1'b0, R2, R1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, R0, 1'b1, 1'b0, IA, 1'b0, 1'b0, R2, R1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, R3, 1'b0, 1'b0, IA, 1'b1, 1'b0, R3, R1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b0, 1'b0, IA, 1'b0, 1'b0, R3, R1};

    // Reset state of both instances
    #12;
    chk("reset_a", {a_rd, a_wr, a_addr, a_wd, a_be, a_iv, a_dd, a_ird, a_drd, a_berr}, '0);
    chk("reset_b", {b_rd, b_wr, b_addr, b_wd, b_be, b_iv, b_dd, b_ird, b_drd, b_berr}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: single fetch, contention with data priority, write, waitstated fetch (instance A)
    for (int i = 0; i < NV; i++) begin
      ireq = tbl[i].ireq; dreq = tbl[i].dreq; dwe = tbl[i].dwe;
      mwait = tbl[i].wt; mrdata = tbl[i].rdata;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i),
          {a_rd, a_wr, a_addr, a_iv, a_dd, a_ird, a_drd},
          {tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_addr, tbl[i].e_iv, tbl[i].e_dd,
           tbl[i].e_ird, tbl[i].e_drd});
      @(negedge clk);
    end

    // Waitstated write: 5 waitrequest cycles, stable bus fields, readdata untouched
    daddr = 32'h0000_2000; dbe = 4'b0011; dwdata = 32'hDEAD_BEEF; dwe = 1'b1;
    dreq = 1'b1; mwait = 1'b1; mrdata = 32'h1234_5678;
    wcnt = 0; stable = 1'b1; got = 1'b0; done_c = -1; last_wr_c = -1; rd_seen_wr = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(posedge clk); #1;
      if (a_wr) begin
        wcnt++; last_wr_c = c;
        if (a_addr !== 32'h0000_2000 || a_be !== 4'b0011 || a_wd !== 32'hDEAD_BEEF) stable = 1'b0;
      end
      if (a_rd) rd_seen_wr = 1'b1;
      if (a_dd) begin got = 1'b1; done_c = c; end
      @(negedge clk);
      mwait = (wcnt < 6) ? 1'b1 : 1'b0;
      if (got) dreq = 1'b0;
    end
    chk("ws_done_seen", 128'(got), 128'(1));
    chk("ws_write_cycles", 128'(wcnt), 128'(6));
    chk("ws_stable_fields", 128'(stable), 128'(1));
    chk("ws_no_read_strobe", 128'(rd_seen_wr), 128'(0));
    chk("ws_done_latency", 128'(done_c - last_wr_c), 128'(1));
    chk("ws_readdata_kept", 128'(a_drd), 128'(R1));
    dwe = 1'b0; mwait = 1'b0;
    @(negedge clk);

    // Timeout on instance A (TIMEOUT=8): stuck waitrequest on a fetch
    iaddr = 32'hBFC0_0100; ireq = 1'b1; mwait = 1'b1;
    rcnt = 0; got = 1'b0; early_err = 1'b0; seen_ird = Z; seen_berr = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      if (a_rd) begin
        rcnt++;
        if (a_berr) early_err = 1'b1;
      end
      if (a_iv) begin got = 1'b1; seen_ird = a_ird; seen_berr = a_berr; end
      @(negedge clk);
      if (got) ireq = 1'b0;
    end
    chk("to_valid_seen", 128'(got), 128'(1));
    chk("to_strobe_cycles", 128'(rcnt), 128'(8));
    chk("to_no_early_error", 128'(early_err), 128'(0));
    chk("to_readdata", 128'(seen_ird), 128'(32'hFFFF_FFFF));
    chk("to_bus_error", 128'(seen_berr), 128'(1));
    mwait = 1'b0;
    repeat (3) @(negedge clk);
    // Normal fetch after the timeout: works, error flag stays sticky
    iaddr = IA; ireq = 1'b1; mrdata = 32'h0A0B_0C0D; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (a_iv) got = 1'b1;
      @(negedge clk);
      if (got) ireq = 1'b0;
    end
    chk("to_after_fetch", {96'(got), a_ird}, {96'(1), 32'h0A0B_0C0D});
    chk("to_error_sticky", 128'(a_berr), 128'(1));

    // Reset in the middle of a waitstated read
    ireq = 1'b1; mwait = 1'b1; rcnt = 0;
    for (int c = 0; c < 20 && rcnt < 3; c++) begin
      @(posedge clk); #1;
      if (a_rd) rcnt++;
      @(negedge clk);
    end
    chk("mr_strobe_before", 128'(a_rd), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mr_async_clear", {a_rd, a_wr, a_addr, a_wd, a_be, a_iv, a_dd, a_ird, a_drd, a_berr}, '0);
    ireq = 1'b0; mwait = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (a_iv || a_dd || a_rd || a_wr) spurious = 1'b1;
      @(negedge clk);
    end
    chk("mr_no_pulse", 128'(spurious), 128'(0));
    ireq = 1'b1; mrdata = 32'h5A5A_A5A5; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (a_iv) got = 1'b1;
      @(negedge clk);
      if (got) ireq = 1'b0;
    end
    chk("mr_after_fetch", {96'(got), a_ird}, {96'(1), 32'h5A5A_A5A5});

    // Round-robin on instance B: pointer starts at "instruction served last"
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ireq = 1'b1; dreq = 1'b1; dwe = 1'b0; daddr = DA; dbe = 4'hF; mwait = 1'b0;
    mrdata = 32'h0000_00AA;
    exp_order[0] = "D"; exp_order[1] = "I"; exp_order[2] = "D";
    exp_order[3] = "I"; exp_order[4] = "D";
    for (int k = 0; k < 5; k++) order[k] = "-";
    npulse = 0;
    for (int c = 0; c < 60 && npulse < 5; c++) begin
      @(posedge clk); #1;
      if (b_iv && b_dd) begin
        order[npulse] = "X"; npulse++;
      end else if (b_iv) begin
        order[npulse] = "I"; npulse++;
      end else if (b_dd) begin
        order[npulse] = "D"; npulse++;
      end
      @(negedge clk);
    end
    ireq = 1'b0; dreq = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant%0d", k), 128'(order[k]), 128'(exp_order[k]));
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
